// File: rtl/uart_tx_shift_reg_if.sv
// uart_tx_shift_reg_if: byte load / shift strobe / serial out bus between TX controller and shift register.
// Carries bits_left_o/empty_o when UART_TX_SHIFT_COUNT_EN is defined.
interface uart_tx_shift_reg_if #(parameter int DW = 8);
  localparam int CW = $clog2(DW + 1);
  logic [DW-1:0] data_i;
  logic          shift_i;
  logic          load_byte_i;
  logic          serial_o;
`ifdef UART_TX_SHIFT_COUNT_EN
  logic [CW-1:0] bits_left_o;
  logic          empty_o;
  modport master (output data_i, shift_i, load_byte_i, input serial_o, bits_left_o, empty_o);
  modport slave (input data_i, shift_i, load_byte_i, output serial_o, bits_left_o, empty_o);
`else
  modport master (output data_i, shift_i, load_byte_i, input serial_o);
  modport slave (input data_i, shift_i, load_byte_i, output serial_o);
`endif
endinterface

// File: rtl/uart_tx_shift_reg.sv
// uart_tx_shift_reg: UART TX PISO shift register, LSB first, back-filled with FILL_BIT.
// Define UART_TX_SHIFT_COUNT_EN to add the bits_left_o/empty_o byte counter.
module uart_tx_shift_reg #(
  parameter int   DW       = 8,
  parameter logic FILL_BIT = 1'b1
) (
  input logic                clk_i,
  input logic                rst_i,
  uart_tx_shift_reg_if.slave bus
);
  logic [DW-1:0] r_sr;
  always_ff @(posedge clk_i)
    if (!rst_i) r_sr <= {DW{FILL_BIT}};
    else if (bus.load_byte_i) r_sr <= bus.data_i;
    else if (bus.shift_i) r_sr <= {FILL_BIT, r_sr[DW-1:1]};
  assign bus.serial_o = r_sr[0];
`ifdef UART_TX_SHIFT_COUNT_EN
  localparam int CW = $clog2(DW + 1);
  logic [CW-1:0] r_bits_left;
  // Saturates at zero so over-shifting keeps empty_o asserted.
  always_ff @(posedge clk_i)
    if (!rst_i) r_bits_left <= '0;
    else if (bus.load_byte_i) r_bits_left <= CW'(DW);
    else if (bus.shift_i && r_bits_left != '0) r_bits_left <= r_bits_left - 1'b1;
  assign bus.bits_left_o = r_bits_left;
  assign bus.empty_o     = r_bits_left == '0;
`endif
endmodule

// File: tb/tb_uart_tx_shift_reg.sv
// tb_uart_tx_shift_reg: directed self-checking bench for uart_tx_shift_reg.
module tb_uart_tx_shift_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  uart_tx_shift_reg_if #(.DW(8)) bus ();
  uart_tx_shift_reg #(.DW(8), .FILL_BIT(1'b1)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic l, input logic s, input logic [7:0] d);
    rst_n = r;
    bus.load_byte_i = l;
    bus.shift_i = s;
    bus.data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (bus.serial_o !== 1'b1) begin
        errors++;
        $display("FAIL reset cyc%0d: serial_o=%b expected 1", i, bus.serial_o);
      end
`ifdef UART_TX_SHIFT_COUNT_EN
      checks++;
      if (bus.bits_left_o !== 4'd0 || bus.empty_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_count cyc%0d: bits_left=%0d empty=%b expected 0/1", i, bus.bits_left_o, bus.empty_o);
      end
`endif
    end
  endtask

  task automatic test_load_shift;
    logic exp_seq [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      if (i == 0) step(1'b1, 1'b1, 1'b0, 8'hA5);
      else step(1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.serial_o !== exp_seq[i]) begin
        errors++;
        $display("FAIL load_shift A5 step%0d: serial_o=%b expected %b", i, bus.serial_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic exp_seq [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h80);
      checks++;
      if (bus.serial_o !== 1'b0) begin
        errors++;
        $display("FAIL simul_load_wins cyc%0d: serial_o=%b expected 0", i, bus.serial_o);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h80);
      checks++;
      if (bus.serial_o !== exp_seq[i]) begin
        errors++;
        $display("FAIL simul_drain shift%0d: serial_o=%b expected %b", i + 1, bus.serial_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_hold;
    step(1'b1, 1'b1, 1'b0, 8'h02);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b1, 1'b0, 1'b0, 8'hFF);
      checks++;
      if (bus.serial_o !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc%0d: serial_o=%b expected 0", i, bus.serial_o);
      end
    end
    step(1'b1, 1'b0, 1'b1, 8'hFF);
    checks++;
    if (bus.serial_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_then_shift: serial_o=%b expected 1", bus.serial_o);
    end
  endtask

  task automatic test_mid_operation;
    step(1'b1, 1'b1, 1'b0, 8'h0F);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step(1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.serial_o !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_ff shift%0d: serial_o=%b expected 1", i, bus.serial_o);
      end
    end
    step(1'b1, 1'b1, 1'b0, 8'hF0);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.serial_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_f0_shift: serial_o=%b expected 0", bus.serial_o);
    end
    step(1'b1, 1'b1, 1'b1, 8'h01);
    checks++;
    if (bus.serial_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reload_01: serial_o=%b expected 1", bus.serial_o);
    end
    step(1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.serial_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reload_01_shift: serial_o=%b expected 0", bus.serial_o);
    end
  endtask

`ifdef UART_TX_SHIFT_COUNT_EN
  task automatic test_count;
    logic [3:0] exp_left [10] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    logic       exp_empty [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      if (i == 0) step(1'b1, 1'b1, 1'b1, 8'h3C);
      else step(1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.bits_left_o !== exp_left[i] || bus.empty_o !== exp_empty[i]) begin
        errors++;
        $display("FAIL count shift%0d: bits_left=%0d empty=%b expected %0d/%b", i, bus.bits_left_o, bus.empty_o, exp_left[i], exp_empty[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.load_byte_i = 1'b0;
    bus.shift_i = 1'b0;
    bus.data_i = 8'h00;
    test_reset();
    test_load_shift();
    test_simultaneous();
    test_hold();
    test_mid_operation();
`ifdef UART_TX_SHIFT_COUNT_EN
    test_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
